// File: rtl/polar_encoder_pkg.sv
// Shared types and helpers for the serial polar encoder.
// bit_reverse is used only when POLAR_ENC_BIT_REVERSE_EN is defined.
package polar_encoder_pkg;

    typedef enum logic [1:0] {
        LOAD   = 2'd0,
        ENCODE = 2'd1,
        OUTPUT = 2'd2
    } state_t;

    // Reverse the low 'width' bits of 'value'.
    function automatic int unsigned bit_reverse(input int unsigned value,
                                                input int unsigned width);
        int unsigned result;
        result = 0;
        for (int unsigned i = 0; i < width; i++) begin
            result = (result << 1) | ((value >> i) & 1);
        end
        return result;
    endfunction

    // Number of frozen positions (ones) in the low n bits of mask.
    function automatic int unsigned frozen_count(input logic [1023:0] mask,
                                                 input int unsigned n);
        int unsigned count;
        count = 0;
        for (int unsigned i = 0; i < n; i++) begin
            if (mask[i]) count++;
        end
        return count;
    endfunction

endpackage

// File: rtl/polar_enc_stage.sv
// One butterfly stage of x = u * G_N. Every index with bit 'stage' clear
// takes the XOR of itself and its partner; the partner passes through.
module polar_enc_stage
    import polar_encoder_pkg::*;
#(
    parameter int N = 8
) (
    input  logic [N-1:0]         u_in,
    input  logic [$clog2(N)-1:0] stage,
    output logic [N-1:0]         u_out
);

    localparam int IDX_W = $clog2(N);

    // Butterfly for the selected stage: left <- left ^ right, right <- right.
    always_comb begin
        // NOTE: assigning a default before the loop keeps every bit driven on
        // every path, so no latch is inferred.
        u_out = u_in;
        for (int i = 0; i < N; i++) begin
            if (((i >> stage) & 1) == 0) begin
                u_out[i] = u_in[i] ^ u_in[IDX_W'(i | (1 << stage))];
            end
        end
    end

endmodule

// File: rtl/polar_encoder.sv
// Serial-in/serial-out polar encoder: loads K info bits into the non-frozen
// positions of u, runs log2(N) in-place butterfly stages, streams N bits out.
// Optional build macro: POLAR_ENC_BIT_REVERSE_EN selects bit-reversed output order.
module polar_encoder
    import polar_encoder_pkg::*;
#(
    parameter int           N           = 8,
    parameter int           K           = 4,
    parameter logic [N-1:0] FROZEN_MASK = 8'b0001_0111
) (
    input  logic clk,
    input  logic rst_n,
    input  logic in_valid,
    output logic in_ready,
    input  logic in_bit,
    output logic out_valid,
    input  logic out_ready,
    output logic out_bit,
    output logic out_last
);

    localparam int LOG_N = $clog2(N);
    localparam int IDX_W = LOG_N;
    localparam int unsigned N_FROZEN = frozen_count(1024'(FROZEN_MASK), N);

    if (N < 2 || (N & (N - 1)) != 0) begin : g_bad_n
        $error("polar_encoder: N=%0d is not a power of two", N);
    end
    if (K > N) begin : g_bad_k
        $error("polar_encoder: K=%0d exceeds N=%0d", K, N);
    end
    if (N - N_FROZEN != K) begin : g_bad_mask
        $error("polar_encoder: FROZEN_MASK has %0d info positions, K=%0d", N - N_FROZEN, K);
    end

    state_t           state, next_state;
    logic [N-1:0]     u;
    logic [N-1:0]     u_next;
    logic [IDX_W-1:0] info_cnt;
    logic [IDX_W-1:0] stage;
    logic [IDX_W-1:0] idx;
    logic [IDX_W-1:0] wr_idx;
    logic [IDX_W-1:0] sel;

    wire info_done  = (info_cnt == IDX_W'(K - 1));
    wire stage_done = (stage == IDX_W'(LOG_N - 1));
    wire idx_done   = (idx == IDX_W'(N - 1));

    polar_enc_stage #(.N(N)) u_stage (
        .u_in  (u),
        .stage (stage),
        .u_out (u_next)
    );

    // Locate the info_cnt-th non-frozen index: the write target for the next info bit.
    always_comb begin
        int seen;
        seen   = 0;
        wr_idx = '0;
        for (int i = 0; i < N; i++) begin
            if (!FROZEN_MASK[i]) begin
                if (seen == int'(info_cnt)) wr_idx = IDX_W'(i);
                seen++;
            end
        end
    end

    // Output read address: natural or bit-reversed order.
    always_comb begin
`ifdef POLAR_ENC_BIT_REVERSE_EN
        sel = IDX_W'(bit_reverse(32'(idx), LOG_N));
`else
        sel = idx;
`endif
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (!rst_n) state <= LOAD;
        else        state <= next_state;
    end

    // Next-state logic and handshake/output decode.
    always_comb begin
        next_state = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        out_bit    = 1'b0;
        out_last   = 1'b0;
        case (state)
            LOAD: begin
                in_ready = 1'b1;
                if (in_valid && info_done) next_state = ENCODE;
            end
            ENCODE: begin
                if (stage_done) next_state = OUTPUT;
            end
            OUTPUT: begin
                out_valid = 1'b1;
                out_bit   = u[sel];
                out_last  = idx_done;
                if (out_ready && idx_done) next_state = LOAD;
            end
            default: next_state = LOAD;
        endcase
    end

    // Datapath: info bit capture, butterfly stages, output index.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: u is a flop vector, not a RAM, so it is reset like any other
        // state; frozen positions must read 0 from the very first frame.
        if (!rst_n) begin
            u        <= '0;
            info_cnt <= '0;
            stage    <= '0;
            idx      <= '0;
        end else begin
            case (state)
                LOAD: begin
                    if (in_valid) begin
                        u[wr_idx] <= in_bit;
                        if (info_done) begin
                            info_cnt <= '0;
                            stage    <= '0;
                        end else begin
                            info_cnt <= info_cnt + 1'b1;
                        end
                    end
                end
                ENCODE: begin
                    u     <= u_next;
                    stage <= stage + 1'b1;
                    if (stage_done) idx <= '0;
                end
                OUTPUT: begin
                    if (out_ready) begin
                        if (idx_done) begin
                            idx <= '0;
                            u   <= '0;  // frozen positions start the next frame cleared
                        end else begin
                            idx <= idx + 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_polar_encoder.sv
// Self-checking bench for polar_encoder with a generator-matrix reference model.
module tb_polar_encoder;

    localparam int           N           = 8;
    localparam int           K           = 4;
    localparam int           LOG_N       = 3;
    localparam logic [N-1:0] FROZEN_MASK = 8'b0001_0111;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic in_valid = 1'b0;
    logic in_bit = 1'b0;
    logic out_ready = 1'b0;
    logic in_ready, out_valid, out_bit, out_last;

    int n_checks = 0;
    int n_fail   = 0;

    polar_encoder #(.N(N), .K(K), .FROZEN_MASK(FROZEN_MASK)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_bit    (in_bit),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_bit   (out_bit),
        .out_last  (out_last)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, actual, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int rev_bits(input int v);
        int r;
        r = 0;
        for (int i = 0; i < LOG_N; i++) r = (r << 1) | ((v >> i) & 1);
        return r;
    endfunction

    // x = u * G_N with G_N = F^(kron n): x[i] is the XOR of u[j] over all j
    // whose set bits cover the set bits of i. Returned in transmit order.
    function automatic logic [N-1:0] model(input logic [K-1:0] info);
        logic [N-1:0] u;
        logic [N-1:0] x;
        logic [N-1:0] tx;
        int k;
        u = '0;
        k = 0;
        for (int i = 0; i < N; i++) begin
            if (!FROZEN_MASK[i]) begin
                u[i] = info[k];
                k++;
            end
        end
        for (int i = 0; i < N; i++) begin
            x[i] = 1'b0;
            for (int j = 0; j < N; j++) begin
                if ((j & i) == i) x[i] = x[i] ^ u[j];
            end
        end
        for (int t = 0; t < N; t++) begin
`ifdef POLAR_ENC_BIT_REVERSE_EN
            tx[t] = x[rev_bits(t)];
`else
            tx[t] = x[t];
`endif
        end
        return tx;
    endfunction

    task automatic do_reset(input string tag);
        in_valid  = 1'b0;
        out_ready = 1'b0;
        rst_n     = 1'b0;
        #2;
        check({tag, "_in_ready"},  in_ready,  1);
        check({tag, "_out_valid"}, out_valid, 0);
        check({tag, "_out_bit"},   out_bit,   0);
        check({tag, "_out_last"},  out_last,  0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
    endtask

    // Send one frame and collect its output. stop_in / stop_out abandon the
    // frame after that many input / output handshakes (K / N = full frame).
    task automatic run_frame(input logic [K-1:0] info, input bit random_bp,
                             input bit gaps, input int stop_in, input int stop_out);
        logic [N-1:0] expv;
        int waited, got, cycles;
        expv = model(info);

        for (int k = 0; k < K; k++) begin
            if (k == stop_in) begin
                in_valid = 1'b0;
                return;
            end
            if (gaps) begin
                in_valid = 1'b0;
                repeat ($urandom_range(0, 2)) tick();
            end
            in_valid = 1'b1;
            in_bit   = info[k];
            check("in_ready_load", in_ready, 1);
            tick();
        end
        in_valid = 1'b0;
        in_bit   = 1'b0;

        waited = 0;
        while (out_valid !== 1'b1 && waited < 64) begin
            if (waited == 0) check("in_ready_encode", in_ready, 0);
            tick();
            waited++;
        end
        check("latency", waited, LOG_N);

        got    = 0;
        cycles = 0;
        while (got < N && cycles < 1000) begin
            if (got == stop_out) return;
            out_ready = random_bp ? 1'($urandom_range(0, 1)) : 1'b1;
            @(negedge clk);
            check("out_valid", out_valid, 1);
            check($sformatf("out_bit[%0d]", got), out_bit, expv[got]);
            check($sformatf("out_last[%0d]", got), out_last, (got == N - 1) ? 1 : 0);
            if (out_ready) got++;
            tick();
            cycles++;
        end
        out_ready = 1'b0;
        check("frame_bits", got, N);
        if (!random_bp) check("output_cycles", cycles, N);
        check("in_ready_after_last", in_ready, 1);
        check("out_valid_after_last", out_valid, 0);
    endtask

    initial begin
        do_reset("reset");

        // Directed frames: all ones, last info index only, first info index only.
        run_frame(4'b1111, 1'b0, 1'b0, K, N);
        run_frame(4'b1000, 1'b0, 1'b0, K, N);
        run_frame(4'b0001, 1'b0, 1'b0, K, N);

        // Randomized frames with back-pressure and input gaps.
        repeat (24) run_frame(K'($urandom), 1'b1, 1'b1, K, N);
        repeat (6)  run_frame(K'($urandom), 1'b0, 1'b0, K, N);

        // Reset after two info bits, then a full frame.
        run_frame(K'($urandom), 1'b0, 1'b1, 2, N);
        do_reset("reset_mid_load");
        run_frame(4'b1111, 1'b0, 1'b0, K, N);

        // Reset after three output bits, then a full frame.
        run_frame(K'($urandom), 1'b1, 1'b0, K, 3);
        do_reset("reset_mid_out");
        run_frame(4'b0001, 1'b1, 1'b1, K, N);
        run_frame(K'($urandom), 1'b0, 1'b0, K, N);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/polar_encoder.md
# polar_encoder

Serial-in/serial-out polar encoder: the transmit-side counterpart of the polar SC decoder datapath. It accepts K information bits over a valid/ready stream and places them at the non-frozen indices of an N-bit vector u, with frozen positions forced to 0. It computes x = u·G_N in place, one butterfly stage per cycle, using the same partial-sum rule as the decoder's beta update: left ← left ^ right, right ← right. It then streams the N coded bits out over a valid/ready stream, with a last marker on the final bit.

## Interface
- N, 8, code length; power of two, 2..1024.
- K, 4, information bits per frame; 1 ≤ K ≤ N.
- FROZEN_MASK, 8'b0001_0111, N bits; bit i = 1 means index i is frozen (forced to 0).
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  in_bit is valid.
- in_ready  out  1  encoder accepts an info bit this cycle.
- in_bit  in  1  information bit.
- out_valid  out  1  out_bit is valid.
- out_ready  in  1  downstream accepts out_bit.
- out_bit  out  1  coded bit.
- out_last  out  1  high with the final coded bit of the frame.

## Operation
- There are three states: LOAD, ENCODE and OUTPUT. Reset enters LOAD.
- **LOAD:**
  - in_ready = 1.
  - Each in_valid && in_ready handshake writes in_bit to the next non-frozen index, in ascending index order.
  - Frozen bits of u are cleared on entry to LOAD.
  - After the K-th handshake, the state moves to ENCODE and the stage counter s is set to 0.
- **ENCODE:**
  - in_ready = 0 and out_valid = 0.
  - Each cycle, for every i with bit s of i clear: u[i] ← u[i] ^ u[i | 2^s].
  - s increments each cycle. After stage log2(N)−1, the state moves to OUTPUT and the output index is set to 0.
- **OUTPUT:**
  - out_valid = 1 and out_bit = u[idx].
  - out_last = 1 when idx = N−1.
  - idx advances only on out_valid && out_ready.
  - The handshake on idx = N−1 returns the state to LOAD.
- Holding out_ready low stalls OUTPUT indefinitely; out_bit and out_last stay stable while stalled.
- Frames do not overlap: no input is accepted in ENCODE or OUTPUT.
- Elaboration-time checks, each an $error:
  - N is not a power of two;
  - K > N;
  - the count of zeros in FROZEN_MASK differs from K.

## Timing
- Reset values:
  - in_ready = 1 (state LOAD);
  - out_valid = 0, out_bit = 0, out_last = 0;
  - u, all counters and the stage counter = 0.
- Asserting rst_n mid-frame discards the partial frame; the next frame starts from info index 0.
- Latency: the last info bit is captured at edge E. The log2(N) encode stages run at edges E+1 … E+log2(N). out_valid is first high in the cycle after edge E+log2(N).
- With out_ready held high, OUTPUT lasts exactly N cycles.
- in_ready is high in the cycle after the out_last handshake.
- Total frame period with no back-pressure: K + log2(N) + N cycles.

## Configuration
- POLAR_ENC_BIT_REVERSE_EN:
  - Defined: OUTPUT emits u[bitrev(idx)], where bitrev reverses the log2(N) bits of idx. This gives the bit-reversed transmit order.
  - Undefined: natural order u[idx].
  - Control timing and out_last are identical in both builds.

## Structure
- polar_encoder_pkg holds:
  - the state enum typedef (LOAD, ENCODE, OUTPUT);
  - a bit_reverse function parameterised by log2(N);
  - a frozen-count function used by the elaboration check.
- Sub-module polar_enc_stage: a combinational N-bit butterfly for a selected stage s. It is instantiated once and its result is registered into u.

## Test plan
Defaults N=8, K=4, FROZEN_MASK=8'b0001_0111 (info indices 3, 5, 6, 7).
- **All-ones frame:** info 1,1,1,1 → out_bit sequence idx0..7 = 0,1,1,0,1,0,0,1; out_last only on the 8th bit.
- **Last info index:** info 0,0,0,1 (u7=1) → all eight coded bits = 1.
- **First info index:** info 1,0,0,0 (u3=1) → 1,1,1,1,0,0,0,0.
  - With POLAR_ENC_BIT_REVERSE_EN defined → 1,0,1,0,1,0,1,0.
- **Timing:** last info bit at edge E → out_valid is first high after edge E+3. With out_ready = 1, in_ready returns 8 cycles later.
- **Back-pressure:** random out_ready and gaps in in_valid → same bit sequences; no bit dropped or duplicated; out_bit and out_last stable while stalled.
- **Reset mid-frame:** rst_n low after 2 info bits, or after 3 output bits → outputs take reset values and the next full frame encodes correctly.
